// File: rtl/jesd204b_dl_tx_multilane.sv
`default_nettype none
// ============================================================================
// Module   : jesd204b_dl_tx_multilane
// Brief    : JESD204B transmit data link layer for LANES lanes (4 octets per
//            lane per clk). Runs CGS -> ILAS -> DATA against the receiver's
//            SYNC~, generates the LMFC and per-octet frame/multiframe markers.
//            Optional per-lane 1 + x^14 + x^15 scrambler, compiled in only when
//            the macro JESD_DL_SCRAMBLE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module jesd204b_dl_tx_multilane #(
    parameter int LANES         = 2,
    parameter int OCTETS_PER_FR = 2,
    parameter int FRAMES_PER_MF = 16,
    parameter int ILAS_MF       = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sync_n,
    input  logic                scramble_enable,
    input  logic [14*8-1:0]     in_config,
    input  logic [32*LANES-1:0] in,
    output logic                in_ready,
    output logic [32*LANES-1:0] out_tx,
    output logic [4*LANES-1:0]  out_k,
    output logic [3:0]          sof,
    output logic [3:0]          eof,
    output logic [3:0]          som,
    output logic [3:0]          eom,
    output logic                LMFC,
    output logic [1:0]          link_state
);

    localparam int c_FK     = OCTETS_PER_FR * FRAMES_PER_MF;
    localparam int c_MF_CYC = c_FK / 4;
    localparam int c_MF_W   = $clog2(c_MF_CYC);
    localparam int c_ILAS_W = $clog2(ILAS_MF);

    localparam logic [c_MF_W-1:0]   c_MF_LAST   = c_MF_W'(c_MF_CYC - 1);
    localparam logic [c_ILAS_W-1:0] c_ILAS_LAST = c_ILAS_W'(ILAS_MF - 1);
    localparam logic [c_ILAS_W-1:0] c_ILAS_CFG  = c_ILAS_W'(1);
    localparam logic [15:0]         c_F16       = 16'(OCTETS_PER_FR);
    localparam logic [15:0]         c_FK16      = 16'(c_FK);
    localparam logic [31:0]         c_CGS_WORD  = 32'hBCBCBCBC;

    typedef enum logic [1:0] {
        S_CGS  = 2'd0,
        S_ILAS = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_MF_W-1:0]     r_mf_cnt;
    logic [c_ILAS_W-1:0]   r_ilas_mf;
    logic                  r_sync_d;
    logic                  r_sync_flag;
    logic                  w_mf_last;
    logic                  w_armed;
    logic                  w_ilas_done;
    logic [15:0]           w_base;
    logic [3:0]            w_sof;
    logic [3:0]            w_eof;
    logic [3:0]            w_som;
    logic [3:0]            w_eom;
    logic [31:0]           w_ilas_word;
    logic [3:0]            w_ilas_k;
    logic [32*LANES-1:0]   w_tx;
    logic [4*LANES-1:0]    w_k;

    assign w_mf_last   = (r_mf_cnt == c_MF_LAST);
    // A rising edge on SYNC~ counts immediately; the flag keeps it until LMFC.
    assign w_armed     = sync_n & (r_sync_flag | ~r_sync_d);
    assign w_ilas_done = w_mf_last & (r_ilas_mf == c_ILAS_LAST);
    assign w_base      = 16'(r_mf_cnt) << 2;
    assign link_state  = r_state;

    // Free-running multiframe counter, independent of the link state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mf_cnt <= '0;
        end else if (w_mf_last) begin
            r_mf_cnt <= '0;
        end else begin
            r_mf_cnt <= r_mf_cnt + 1'b1;
        end
    end

    // SYNC~ rising-edge capture; only meaningful while waiting in CGS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_d    <= 1'b0;
            r_sync_flag <= 1'b0;
        end else begin
            r_sync_d    <= sync_n;
            r_sync_flag <= (r_state == S_CGS) ? w_armed : 1'b0;
        end
    end

    // ILAS multiframe index, restarted whenever the link is not in ILAS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ilas_mf <= '0;
        end else if (r_state != S_ILAS) begin
            r_ilas_mf <= '0;
        end else if (w_mf_last) begin
            r_ilas_mf <= r_ilas_mf + 1'b1;
        end
    end

    // Link state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CGS;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Link-up sequencing; a low SYNC~ always wins over the ILAS->DATA step.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_CGS:  if (w_armed && w_mf_last) w_state_next = S_ILAS;
            S_ILAS: begin
                if (!sync_n)          w_state_next = S_CGS;
                else if (w_ilas_done) w_state_next = S_DATA;
            end
            S_DATA: if (!sync_n) w_state_next = S_CGS;
            default: w_state_next = S_CGS;
        endcase
    end

    // Per-octet markers and the ILAS word (identical on every lane).
    always_comb begin : p_octets
        logic [15:0] v_p;
        w_sof       = '0;
        w_eof       = '0;
        w_som       = '0;
        w_eom       = '0;
        w_ilas_word = '0;
        w_ilas_k    = '0;
        for (int i = 0; i < 4; i++) begin
            v_p                  = w_base + 16'(i);
            w_sof[i]             = ((v_p % c_F16) == 16'd0);
            w_eof[i]             = ((v_p % c_F16) == (c_F16 - 16'd1));
            w_som[i]             = (v_p == 16'd0);
            w_eom[i]             = (v_p == (c_FK16 - 16'd1));
            w_ilas_word[8*i +: 8] = v_p[7:0];
            if (v_p == 16'd0) begin
                w_ilas_word[8*i +: 8] = 8'h1C;
                w_ilas_k[i]           = 1'b1;
            end else if (v_p == (c_FK16 - 16'd1)) begin
                w_ilas_word[8*i +: 8] = 8'h7C;
                w_ilas_k[i]           = 1'b1;
            end else if (r_ilas_mf == c_ILAS_CFG) begin
                if (v_p == 16'd1) begin
                    w_ilas_word[8*i +: 8] = 8'h9C;
                    w_ilas_k[i]           = 1'b1;
                end else begin
                    for (int j = 0; j < 14; j++) begin
                        if (v_p == 16'(j + 2)) w_ilas_word[8*i +: 8] = in_config[8*j +: 8];
                    end
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] w_din;
        logic [31:0] w_dout;
        assign w_din = in[32*l +: 32];
`ifdef JESD_DL_SCRAMBLE_EN
        localparam logic [14:0] c_SCR_SEED = 15'h7FFF;
        logic [14:0] r_scr;
        logic [14:0] w_scr_next;
        logic [31:0] w_scr_out;

        // Serial scrambler unrolled over 32 bits: octet 0 first, MSB first.
        always_comb begin : p_scramble
            logic [14:0] v_s;
            v_s       = r_scr;
            w_scr_out = '0;
            for (int o = 0; o < 4; o++) begin
                for (int b = 7; b >= 0; b--) begin
                    w_scr_out[8*o+b] = w_din[8*o+b] ^ v_s[13] ^ v_s[14];
                    v_s              = {v_s[13:0], w_scr_out[8*o+b]};
                end
            end
            w_scr_next = v_s;
        end

        // Scrambler state: reseeded on DATA entry, held while bypassed.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_scr <= c_SCR_SEED;
            end else if (r_state == S_ILAS && w_state_next == S_DATA) begin
                r_scr <= c_SCR_SEED;
            end else if (r_state == S_DATA && scramble_enable) begin
                r_scr <= w_scr_next;
            end
        end

        assign w_dout = scramble_enable ? w_scr_out : w_din;
`else
        assign w_dout = w_din;
`endif
        assign w_tx[32*l +: 32] = (r_state == S_DATA) ? w_dout :
                                  (r_state == S_ILAS) ? w_ilas_word : c_CGS_WORD;
        assign w_k[4*l +: 4]    = (r_state == S_DATA) ? 4'h0 :
                                  (r_state == S_ILAS) ? w_ilas_k : 4'hF;
    end

`ifndef JESD_DL_SCRAMBLE_EN
    logic w_unused;
    assign w_unused = scramble_enable;
`endif

    // Output register stage: everything leaves the block one clk after use.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_tx   <= '0;
            out_k    <= '0;
            sof      <= '0;
            eof      <= '0;
            som      <= '0;
            eom      <= '0;
            LMFC     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            out_tx   <= w_tx;
            out_k    <= w_k;
            sof      <= w_sof;
            eof      <= w_eof;
            som      <= w_som;
            eom      <= w_eom;
            LMFC     <= (r_mf_cnt == '0);
            in_ready <= (w_state_next == S_DATA);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jesd204b_dl_tx_multilane.sv
`default_nettype none
// ============================================================================
// Module   : tb_jesd204b_dl_tx_multilane
// Brief    : Directed self-checking bench for jesd204b_dl_tx_multilane with
//            LANES=2, F=2, K=16, ILAS_MF=4 (8 clk per multiframe).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jesd204b_dl_tx_multilane;

    logic          clk = 1'b0;
    logic          reset;
    logic          sync_n;
    logic          scramble_enable;
    logic [111:0]  in_config;
    logic [63:0]   din;
    logic          in_ready;
    logic [63:0]   out_tx;
    logic [7:0]    out_k;
    logic [3:0]    sof, eof, som, eom;
    logic          lmfc;
    logic [1:0]    link_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit scr_q[$];

    localparam logic [63:0] CGS64 = 64'hBCBCBCBC_BCBCBCBC;

    jesd204b_dl_tx_multilane #(
        .LANES(2), .OCTETS_PER_FR(2), .FRAMES_PER_MF(16), .ILAS_MF(4)
    ) dut (
        .clk(clk), .reset(reset), .sync_n(sync_n), .scramble_enable(scramble_enable),
        .in_config(in_config), .in(din), .in_ready(in_ready), .out_tx(out_tx),
        .out_k(out_k), .sof(sof), .eof(eof), .som(som), .eom(eom),
        .LMFC(lmfc), .link_state(link_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [63:0] dup(input logic [31:0] w);
        return {w, w};
    endfunction

    // Reference scrambler: queue of transmitted bits, newest at the back.
    task automatic scr_model(input logic [31:0] d, output logic [31:0] r);
        bit sb;
        r = '0;
        for (int o = 0; o < 4; o++) begin
            for (int b = 7; b >= 0; b--) begin
                sb = d[8*o+b] ^ scr_q[scr_q.size()-14] ^ scr_q[scr_q.size()-15];
                r[8*o+b] = sb;
                scr_q.push_back(sb);
            end
        end
    endtask

    initial begin
        int ph;
        logic [31:0] v0, v1, m;
        logic [31:0] exp32;

        reset = 1'b0;
        sync_n = 1'b0;
        scramble_enable = 1'b0;
        din = '0;
        for (int j = 0; j < 14; j++) in_config[8*j +: 8] = 8'hA0 + 8'(j);

        // 1. reset state and CGS
        repeat (5) @(posedge clk);
        #1;
        check("rst_out_tx", out_tx, 64'h0);
        check("rst_out_k", {56'h0, out_k}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready}, 64'h0);
        check("rst_link_state", {62'h0, link_state}, 64'h0);
        check("rst_lmfc", {63'h0, lmfc}, 64'h0);
        reset = 1'b1;
        cyc = 0;
        tick();
        check("cgs_out_tx", out_tx, CGS64);
        check("cgs_out_k", {56'h0, out_k}, 64'hFF);
        check("cgs_in_ready", {63'h0, in_ready}, 64'h0);
        check("cgs_link_state", {62'h0, link_state}, 64'h0);
        check("cgs_lmfc_first", {63'h0, lmfc}, 64'h1);
        check("cgs_som_first", {60'h0, som}, 64'h1);

        // 2. free-running markers
        while (cyc < 16) begin
            tick();
            ph = (cyc - 1) % 8;
            check("mk_lmfc", {63'h0, lmfc}, (ph == 0) ? 64'h1 : 64'h0);
            check("mk_som", {60'h0, som}, (ph == 0) ? 64'h1 : 64'h0);
            check("mk_eom", {60'h0, eom}, (ph == 7) ? 64'h8 : 64'h0);
            check("mk_sof", {60'h0, sof}, 64'h5);
            check("mk_eof", {60'h0, eof}, 64'hA);
        end

        // 3. SYNC~ high mid-multiframe, ILAS from the next LMFC
        ticks(3);                                    // cyc 19
        sync_n = 1'b1;
        ticks(5);                                    // cyc 24
        check("ilas_pre_state", {62'h0, link_state}, 64'h1);
        check("ilas_pre_tx", out_tx, CGS64);
        tick();                                      // cyc 25
        check("ilas_w0", out_tx, dup(32'h0302011C));
        check("ilas_w0_k", {56'h0, out_k}, 64'h11);
        check("ilas_w0_lmfc", {63'h0, lmfc}, 64'h1);
        tick();                                      // cyc 26
        check("ilas_w1", out_tx, dup(32'h07060504));
        check("ilas_w1_k", {56'h0, out_k}, 64'h00);
        ticks(6);                                    // cyc 32
        check("ilas_w7", out_tx, dup(32'h7C1E1D1C));
        check("ilas_w7_k", {56'h0, out_k}, 64'h88);
        tick();                                      // cyc 33
        check("ilas_mf1_w0", out_tx, dup({in_config[15:0], 8'h9C, 8'h1C}));
        check("ilas_mf1_w0_k", {56'h0, out_k}, 64'h33);
        tick();                                      // cyc 34
        check("ilas_mf1_w1", out_tx, dup(32'hA5A4A3A2));
        ticks(2);                                    // cyc 36
        check("ilas_mf1_w3", out_tx, dup(32'hADACABAA));
        tick();                                      // cyc 37
        check("ilas_mf1_w4", out_tx, dup(32'h13121110));
        ticks(4);                                    // cyc 41
        check("ilas_mf2_w0", out_tx, dup(32'h0302011C));
        check("ilas_mf2_w0_k", {56'h0, out_k}, 64'h11);
        ticks(14);                                   // cyc 55
        check("ilas_end_rdy", {63'h0, in_ready}, 64'h0);
        tick();                                      // cyc 56
        check("ilas_last", out_tx, dup(32'h7C1E1D1C));
        check("data_in_ready", {63'h0, in_ready}, 64'h1);
        check("data_state", {62'h0, link_state}, 64'h2);

        // 4. DATA passthrough
        v0 = 32'h0;
        for (int n = 1; n <= 5; n++) begin
            v0 = v0 + 32'h11111111;
            v1 = v0 + 32'h01020304;
            din = {v1, v0};
            tick();                                  // cyc 57..61
            check("data_tx", out_tx, {v1, v0});
            check("data_k", {56'h0, out_k}, 64'h0);
            check("data_rdy", {63'h0, in_ready}, 64'h1);
            check("data_lmfc", {63'h0, lmfc}, ((cyc - 1) % 8 == 0) ? 64'h1 : 64'h0);
        end

        // 5. resync from DATA
        sync_n = 1'b0;
        din = 64'h66666666_77777777;
        tick();                                      // cyc 62
        check("resync_rdy", {63'h0, in_ready}, 64'h0);
        check("resync_state", {62'h0, link_state}, 64'h0);
        sync_n = 1'b1;
        tick();                                      // cyc 63
        check("resync_tx", out_tx, CGS64);
        check("resync_k", {56'h0, out_k}, 64'hFF);
        check("resync_state2", {62'h0, link_state}, 64'h0);
        tick();                                      // cyc 64
        check("reilas_state", {62'h0, link_state}, 64'h1);
        tick();                                      // cyc 65
        check("reilas_w0", out_tx, dup(32'h0302011C));
        check("reilas_lmfc", {63'h0, lmfc}, 64'h1);

        // SYNC~ low exactly when ILAS would hand over to DATA
        ticks(30);                                   // cyc 95
        check("race_pre_tx", out_tx, dup(32'h1B1A1918));
        sync_n = 1'b0;
        tick();                                      // cyc 96
        check("race_state", {62'h0, link_state}, 64'h0);
        check("race_rdy", {63'h0, in_ready}, 64'h0);
        check("race_last_ilas", out_tx, dup(32'h7C1E1D1C));
        sync_n = 1'b1;
        tick();                                      // cyc 97
        check("race_cgs_tx", out_tx, CGS64);
        ticks(7);                                    // cyc 104
        check("race_reilas_state", {62'h0, link_state}, 64'h1);
        tick();                                      // cyc 105
        check("race_reilas_w0", out_tx, dup(32'h0302011C));
        check("race_reilas_lmfc", {63'h0, lmfc}, 64'h1);
        ticks(31);                                   // cyc 136
        check("data2_rdy", {63'h0, in_ready}, 64'h1);

        // 6. scrambler (model seeded with all ones at DATA entry)
        scr_q.delete();
        for (int i = 0; i < 15; i++) scr_q.push_back(1'b1);
        din = '0;
        scramble_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            scr_model(32'h0, m);
`ifdef JESD_DL_SCRAMBLE_EN
            exp32 = m;
`else
            exp32 = 32'h0;
`endif
            tick();                                  // cyc 137..140
            check("scr_tx", out_tx, dup(exp32));
            check("scr_k", {56'h0, out_k}, 64'h0);
        end
        scramble_enable = 1'b0;
        din = 64'h9ABCDEF0_12345678;
        tick();                                      // cyc 141
        check("scr_bypass", out_tx, 64'h9ABCDEF0_12345678);
        scramble_enable = 1'b1;
        din = '0;
        scr_model(32'h0, m);
`ifdef JESD_DL_SCRAMBLE_EN
        exp32 = m;
`else
        exp32 = 32'h0;
`endif
        tick();                                      // cyc 142
        check("scr_resume", out_tx, dup(exp32));

        // asynchronous reset mid-DATA
        #2;
        reset = 1'b0;
        #1;
        check("arst_tx", out_tx, 64'h0);
        check("arst_k", {56'h0, out_k}, 64'h0);
        check("arst_mk", {48'h0, sof, eof, som, eom}, 64'h0);
        check("arst_lmfc", {63'h0, lmfc}, 64'h0);
        check("arst_rdy", {63'h0, in_ready}, 64'h0);
        check("arst_state", {62'h0, link_state}, 64'h0);
        tick();
        check("arst_hold_tx", out_tx, 64'h0);
        reset = 1'b1;
        tick();
        check("arst_rel_tx", out_tx, CGS64);
        check("arst_rel_k", {56'h0, out_k}, 64'hFF);
        check("arst_rel_lmfc", {63'h0, lmfc}, 64'h1);
        check("arst_rel_state", {62'h0, link_state}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
